// File: rtl/ebpf_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : ebpf_alu_exec_stage
// Purpose  : eBPF ALU/ALU64 execute stage. Single-cycle ops (add, sub, mul,
//            logic, shifts, neg, mov, xor) are registered on the accept
//            edge. DIV/MOD with a non-zero divisor run on an iterative
//            restoring divider that produces one quotient bit per clock.
//            Each instruction yields one registered result, which is
//            handed to writeback over a valid/ready handshake.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            in_valid / in_ready   - instruction handshake
//            in_op, in_alu32       - op nibble, 32-bit mode select
//            in_dst_val/in_src_val - operands
//            in_dst_idx            - destination register index
//            out_valid / out_ready - result handshake
//            out_result, out_dst_idx, out_err - result payload
//            busy                  - divider iterating
// Revision : 1.0 - initial release
// ============================================================================
module ebpf_alu_exec_stage #(
   parameter int XLEN  = 64,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic             in_alu32,
   input  logic [XLEN-1:0]  in_dst_val,
   input  logic [XLEN-1:0]  in_src_val,
   input  logic [IDX_W-1:0] in_dst_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [IDX_W-1:0] out_dst_idx,
   output logic             out_err,
   output logic             busy
);

   localparam int SH_W  = $clog2(XLEN);
   localparam int CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_HOLD = 2'd2   // divide finished, waiting for output register to drain
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // ---------------------------------------------------------------------
   // Operand conditioning
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] w_mask;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   logic [SH_W-1:0] w_sh;
   logic            w_b_zero;
   logic            w_is_divop;

   assign w_mask     = in_alu32 ? {{(XLEN-32){1'b0}}, {32{1'b1}}} : {XLEN{1'b1}};
   assign w_a        = in_dst_val & w_mask;
   assign w_b        = in_src_val & w_mask;
   assign w_sh       = in_alu32 ? SH_W'(in_src_val[4:0]) : in_src_val[SH_W-1:0];
   assign w_b_zero   = (w_b == '0);
   assign w_is_divop = (in_op == 4'h3) || (in_op == 4'h9);

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   logic w_out_free;
   logic w_accept;
   logic w_start_div;

   assign w_out_free  = !out_valid || out_ready;
   assign in_ready    = (r_state == S_IDLE) && w_out_free;
   assign w_accept    = in_valid && in_ready;
   assign w_start_div = w_accept && w_is_divop && !w_b_zero;
   assign busy        = (r_state == S_DIV);

   // ---------------------------------------------------------------------
   // Single-cycle op units
   // ---------------------------------------------------------------------
   logic [31:0]     w_ars32;
   logic [XLEN-1:0] w_ars64;
   logic [XLEN-1:0] w_raw;
   logic            w_err_c;
   logic [XLEN-1:0] w_single_res;

   assign w_ars32 = $signed(w_a[31:0]) >>> w_sh;
   assign w_ars64 = $signed(w_a) >>> w_sh;

   always_comb begin
      w_raw   = '0;
      w_err_c = 1'b0;
      case (in_op)
         4'h0: w_raw = w_a + w_b;
         4'h1: w_raw = w_a - w_b;
         4'h2: w_raw = w_a * w_b;
         4'h3: w_raw = '0;          // only reached on divide by zero
         4'h4: w_raw = w_a | w_b;
         4'h5: w_raw = w_a & w_b;
         4'h6: w_raw = w_a << w_sh;
         4'h7: w_raw = w_a >> w_sh;
         4'h8: w_raw = '0 - w_a;
         4'h9: w_raw = w_a;         // only reached on modulo by zero
         4'hA: w_raw = w_a ^ w_b;
         4'hB: w_raw = w_b;
         4'hC: w_raw = in_alu32 ? {{(XLEN-32){1'b0}}, w_ars32} : w_ars64;
         default: w_err_c = 1'b1;
      endcase
   end

   // Masking restores 32-bit wrap and zero extension after the wide op.
   assign w_single_res = w_raw & w_mask;

   // ---------------------------------------------------------------------
   // Restoring divider. The dividend shifts out of r_quo's MSB while
   // quotient bits shift in at the LSB. ALU32 dividends are left-aligned
   // so the same MSB-first loop works with 32 iterations.
   // ---------------------------------------------------------------------
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [XLEN-1:0]  r_dvs;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_mod;
   logic [IDX_W-1:0] r_div_idx;

   logic [XLEN:0]    w_trial;
   logic             w_ge;
   logic [XLEN-1:0]  w_rem_nxt;
   logic [XLEN-1:0]  w_quo_nxt;
   logic             w_div_last;
   logic             w_div_load;
   logic [XLEN-1:0]  w_div_res;

   assign w_trial    = {r_rem, r_quo[XLEN-1]};
   assign w_ge       = (w_trial >= {1'b0, r_dvs});
   // Difference is below the divisor, so the low XLEN bits are exact.
   assign w_rem_nxt  = w_ge ? (w_trial[XLEN-1:0] - r_dvs) : w_trial[XLEN-1:0];
   assign w_quo_nxt  = {r_quo[XLEN-2:0], w_ge};
   assign w_div_last = (r_state == S_DIV) && (r_cnt == '0);
   assign w_div_load = (w_div_last || (r_state == S_HOLD)) && w_out_free;

   always_comb begin
      if (r_state == S_HOLD) begin
         w_div_res = r_is_mod ? r_rem : r_quo;
      end else begin
         w_div_res = r_is_mod ? w_rem_nxt : w_quo_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start_div) w_state_nxt = S_DIV;
         S_DIV:  if (r_cnt == '0) w_state_nxt = w_out_free ? S_IDLE : S_HOLD;
         S_HOLD: if (w_out_free) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_cnt     <= '0;
         r_is_mod  <= 1'b0;
         r_div_idx <= '0;
      end else if (w_start_div) begin
         r_rem     <= '0;
         r_quo     <= in_alu32 ? (w_a << (XLEN-32)) : w_a;
         r_dvs     <= w_b;
         r_cnt     <= in_alu32 ? CNT_W'(31) : CNT_W'(XLEN-1);
         r_is_mod  <= (in_op == 4'h9);
         r_div_idx <= in_dst_idx;
      end else if (r_state == S_DIV) begin
         r_rem     <= w_rem_nxt;
         r_quo     <= w_quo_nxt;
         r_cnt     <= r_cnt - 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------
   logic             r_out_valid;
   logic [XLEN-1:0]  r_out_result;
   logic [IDX_W-1:0] r_out_idx;
   logic             r_out_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_idx    <= '0;
         r_out_err    <= 1'b0;
      end else if (w_accept && !w_start_div) begin
         r_out_valid  <= 1'b1;
         r_out_result <= w_single_res;
         r_out_idx    <= in_dst_idx;
         r_out_err    <= w_err_c;
      end else if (w_div_load) begin
         r_out_valid  <= 1'b1;
         r_out_result <= w_div_res;
         r_out_idx    <= r_div_idx;
         r_out_err    <= 1'b0;
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_dst_idx = r_out_idx;
   assign out_err     = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_ebpf_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ebpf_alu_exec_stage
// Purpose  : Self-checking bench for ebpf_alu_exec_stage. Directed cases
//            followed by randomized traffic, scored against an arithmetic
//            reference model and an in-order expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ebpf_alu_exec_stage;

   localparam int XLEN  = 64;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_op;
   logic             in_alu32;
   logic [XLEN-1:0]  in_dst_val;
   logic [XLEN-1:0]  in_src_val;
   logic [IDX_W-1:0] in_dst_idx;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [IDX_W-1:0] out_dst_idx;
   logic             out_err;
   logic             busy;

   ebpf_alu_exec_stage #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_alu32    (in_alu32),
      .in_dst_val  (in_dst_val),
      .in_src_val  (in_src_val),
      .in_dst_idx  (in_dst_idx),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_dst_idx (out_dst_idx),
      .out_err     (out_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic [3:0]  idx;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          ncmp = 0;
   int          nfail = 0;
   int          cyc_n = 0;
   int          busy_cnt = 0;
   int          n_out = 0;
   int          last_lat = 0;
   int          last_acc_cyc = 0;
   logic [63:0] last_res = '0;
   logic        last_err = 1'b0;
   bit          last_acc = 1'b0;
   bit          rand_ordy = 1'b0;
   bit          prev_stall = 1'b0;
   logic [63:0] p_res;
   logic [3:0]  p_idx;
   logic        p_err;

   // Reference model: eBPF ALU semantics in plain arithmetic. {err, result}
   function automatic logic [64:0] ref_alu(input logic [3:0] op, input logic a32,
                                           input logic [63:0] d, input logic [63:0] s);
      logic [63:0] m, a, b, r;
      int          sh;
      int          s32;
      longint      s64;
      logic        e;
      m  = a32 ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      a  = d & m;
      b  = s & m;
      sh = a32 ? int'(s[4:0]) : int'(s[5:0]);
      e  = 1'b0;
      r  = '0;
      case (op)
         4'h0: r = a + b;
         4'h1: r = a - b;
         4'h2: r = a * b;
         4'h3: r = (b == 0) ? 64'd0 : a / b;
         4'h4: r = a | b;
         4'h5: r = a & b;
         4'h6: r = a << sh;
         4'h7: r = a >> sh;
         4'h8: r = 64'd0 - a;
         4'h9: r = (b == 0) ? a : a % b;
         4'hA: r = a ^ b;
         4'hB: r = b;
         4'hC: begin
            if (a32) begin
               s32 = int'(a[31:0]);
               s32 = s32 >>> sh;
               r   = {32'd0, 32'(s32)};
            end else begin
               s64 = longint'(a);
               s64 = s64 >>> sh;
               r   = 64'(s64);
            end
         end
         default: begin
            r = '0;
            e = 1'b1;
         end
      endcase
      return {e, r & m};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock: inputs were set at the current negedge; sample just after,
   // score the handshakes that happen at the coming posedge, then advance.
   task automatic tick();
      exp_t        e;
      logic [64:0] rr;
      if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      last_acc = 1'b0;
      if (rst) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid",  64'(out_valid),   64'd1);
            chk("hold_result", out_result,       p_res);
            chk("hold_idx",    64'(out_dst_idx), 64'(p_idx));
            chk("hold_err",    64'(out_err),     64'(p_err));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               e = q.pop_front();
               chk("result", out_result,       e.res);
               chk("dst_idx", 64'(out_dst_idx), 64'(e.idx));
               chk("err",    64'(out_err),      64'(e.err));
               last_res = out_result;
               last_err = out_err;
               last_lat = cyc_n - e.acc;
               n_out++;
            end
         end
         if (in_valid && in_ready) begin
            rr    = ref_alu(in_op, in_alu32, in_dst_val, in_src_val);
            e.res = rr[63:0];
            e.err = rr[64];
            e.idx = in_dst_idx;
            e.acc = cyc_n;
            q.push_back(e);
            last_acc     = 1'b1;
            last_acc_cyc = cyc_n;
         end
         if (busy) busy_cnt++;
         prev_stall = out_valid && !out_ready;
         p_res = out_result;
         p_idx = out_dst_idx;
         p_err = out_err;
      end
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic send(input logic [3:0] op, input logic a32, input logic [63:0] d,
                       input logic [63:0] s, input logic [3:0] idx);
      bit ok;
      ok         = 1'b0;
      in_valid   = 1'b1;
      in_op      = op;
      in_alu32   = a32;
      in_dst_val = d;
      in_src_val = s;
      in_dst_idx = idx;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (last_acc) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 400; k++) begin
         if (q.size() == 0 && !busy && !out_valid) break;
         tick();
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      int          n0;
      int          a_cyc;
      logic [3:0]  op;
      logic [63:0] s;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_op      = '0;
      in_alu32   = 1'b0;
      in_dst_val = '0;
      in_src_val = '0;
      in_dst_idx = '0;
      out_ready  = 1'b1;
      @(negedge clk);
      tick();
      tick();
      tick();

      // Reset state
      chk("rst_out_valid",  64'(out_valid),   64'd0);
      chk("rst_out_result", out_result,       64'd0);
      chk("rst_out_idx",    64'(out_dst_idx), 64'd0);
      chk("rst_out_err",    64'(out_err),     64'd0);
      chk("rst_busy",       64'(busy),        64'd0);
      rst = 1'b0;

      // ADD64 wrap, latency 1
      send(4'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd1);
      idle(2);
      chk("add64_wrap", last_res, 64'd0);
      chk("add64_lat",  64'(last_lat), 64'd1);

      // ALU32 XOR zero-extends
      send(4'hA, 1'b1, 64'h0000_0001_DEAD_BEEF, 64'h0000_0000_FFFF_FFFF, 4'd2);
      idle(2);
      chk("xor32", last_res, 64'h0000_0000_2152_4110);

      // DIV64 / MOD64
      busy_cnt = 0;
      send(4'h3, 1'b0, 64'd100, 64'd7, 4'd3);
      idle(70);
      chk("div64_res",  last_res, 64'd14);
      chk("div64_lat",  64'(last_lat), 64'd65);
      chk("div64_busy", 64'(busy_cnt), 64'd64);
      busy_cnt = 0;
      send(4'h9, 1'b0, 64'd100, 64'd7, 4'd4);
      idle(70);
      chk("mod64_res", last_res, 64'd2);
      chk("mod64_lat", 64'(last_lat), 64'd65);

      // DIV32 by zero / MOD32 by zero
      busy_cnt = 0;
      send(4'h3, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 4'd5);
      idle(2);
      chk("div32_zero_res",  last_res, 64'd0);
      chk("div32_zero_lat",  64'(last_lat), 64'd1);
      chk("div32_zero_busy", 64'(busy_cnt), 64'd0);
      send(4'h9, 1'b1, 64'hABCD_0000_0000_0005, 64'd0, 4'd6);
      idle(2);
      chk("mod32_zero_res", last_res, 64'd5);

      // ADD stream with a 3-cycle writeback stall
      n0 = n_out;
      send(4'h0, 1'b0, 64'd10, 64'd1, 4'd1);
      a_cyc = last_acc_cyc;
      send(4'h0, 1'b0, 64'd20, 64'd2, 4'd2);
      chk("stream_throughput", 64'(last_acc_cyc - a_cyc), 64'd1);
      out_ready = 1'b0;
      idle(3);
      out_ready = 1'b1;
      send(4'h0, 1'b0, 64'd30, 64'd3, 4'd3);
      send(4'h0, 1'b0, 64'd40, 64'd4, 4'd4);
      idle(3);
      chk("stream_count", 64'(n_out - n0), 64'd4);
      chk("stream_last",  last_res, 64'd44);

      // Divide finishing under a stall must wait in hold
      out_ready = 1'b0;
      send(4'h3, 1'b1, 64'd1000, 64'd9, 4'd7);
      idle(40);
      out_ready = 1'b1;
      idle(3);
      chk("stall_div_res", last_res, 64'd111);

      // Reset during divide iteration 20 aborts it
      n0 = n_out;
      send(4'h3, 1'b0, 64'hFFFF_0000_1234_5678, 64'd3, 4'd8);
      idle(20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid",    64'(out_valid), 64'd0);
      chk("abort_busy",     64'(busy),      64'd0);
      chk("abort_in_ready", 64'(in_ready),  64'd1);
      idle(80);
      chk("abort_no_out", 64'(n_out - n0), 64'd0);

      // Illegal op
      send(4'hE, 1'b0, 64'd55, 64'd66, 4'd9);
      idle(2);
      chk("illegal_err", 64'(last_err), 64'd1);
      chk("illegal_res", last_res, 64'd0);

      // Randomized traffic with random writeback back-pressure
      rand_ordy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            idle(1);
         end else begin
            op = 4'($urandom_range(0, 15));
            s  = {$urandom(), $urandom()};
            if (op == 4'h3 || op == 4'h9) begin
               case ($urandom_range(0, 3))
                  0: s = {$urandom(), 32'd0};
                  1: s = 64'($urandom_range(1, 20));
                  default: ;
               endcase
            end
            send(op, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, s,
                 4'($urandom_range(0, 10)));
         end
      end
      rand_ordy = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
`default_nettype wire
